// File: rtl/char_feeder_pkg.sv
// rtl/char_feeder_pkg.sv - shared code constants, FSM encoding and filter helpers
//
// Purpose : character codes recognised by the feeder's input filter, the
//           emitter FSM state type, and the keep/remap helper functions.
// Ports   : none (package).
// Options : ECHO_EN is not used here; see char_stream_feeder.sv.

package char_feeder_pkg;

   localparam logic [6:0] CODE_NUL      = 7'h00;
   localparam logic [6:0] CODE_LF       = 7'h0A;
   localparam logic [6:0] CODE_BS       = 7'h08;
   localparam logic [6:0] CODE_CR       = 7'h0D;
   localparam logic [6:0] CODE_BKSP_SCR = 7'h5C;
   localparam logic [6:0] CODE_CLR      = 7'h7F;
   localparam logic [6:0] CODE_CLR2     = 7'h2F;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STROBE = 2'd1,
      ST_GAP    = 2'd2
   } state_e;

   // NUL and LF never reach the screen; everything else (CR, CLR, CLR2
   // included) is forwarded.
   function automatic logic char_keep(input logic [6:0] code);
      return (code != CODE_NUL) && (code != CODE_LF);
   endfunction

   // Host backspace becomes the screen's own backspace code.
   function automatic logic [6:0] char_map(input logic [6:0] code);
      return (code == CODE_BS) ? CODE_BKSP_SCR : code;
   endfunction

endpackage

// File: rtl/char_stream_feeder_sync_fifo.sv
// rtl/char_stream_feeder_sync_fifo.sv - synchronous FIFO with occupancy count
//
// Purpose : single-clock FIFO, dout shows the head entry combinationally so
//           the consumer can register it on the same edge it pops.
// Ports   : clk, reset_n (async, active-low)
//           wr_en/din   - write request; accepted when not full, or when a
//                         pop happens in the same cycle
//           rd_en/dout  - pop request (ignored when empty) / head entry
//           full, empty, level - status, level is 0..DEPTH

module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] din,
   input  logic             rd_en,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [PTR_W:0]   level
);

   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [PTR_W:0]   LVL_ONE  = (PTR_W + 1)'(1);
   localparam logic [PTR_W:0]   LVL_FULL = (PTR_W + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   level_q, level_d;
   logic             do_wr, do_rd;

   assign full  = (level_q == LVL_FULL);
   assign empty = (level_q == '0);
   assign level = level_q;
   assign dout  = mem[rd_ptr_q];

   // A pop in the same cycle frees a slot, so a write into a full FIFO
   // still succeeds then.
   assign do_rd = rd_en && !empty;
   assign do_wr = wr_en && (!full || do_rd);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_wr) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_rd) rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({do_wr, do_rd})
         2'b10:   level_d = level_q + LVL_ONE;
         2'b01:   level_d = level_q - LVL_ONE;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage needs no reset: pointers define what is valid.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/char_stream_feeder.sv
// rtl/char_stream_feeder.sv - filters received bytes and emits gapped set strobes
//
// Purpose : buffers UART bytes, drops NUL/LF, remaps BS, and emits each
//           character as a one-cycle set strobe with at least GAP idle cycles
//           between strobes.
// Ports   : clk, reset_n (async, active-low)
//           rx_valid/rx_data - received byte {lang, code[6:0]}
//           clr_ovf          - clears the sticky overflow flag
//           set/data_out     - write strobe and character to the screen stage
//           fifo_level       - FIFO occupancy 0..DEPTH
//           overflow         - sticky, a kept byte was lost to a full FIFO
// Options : ECHO_EN adds tx_busy (in), tx_start/tx_data (out); pops wait for
//           tx_busy=0 and each strobe also starts an echo transmission.

module char_stream_feeder
   import char_feeder_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int GAP   = 4,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           rx_valid,
   input  logic [7:0]     rx_data,
   input  logic           clr_ovf,
`ifdef ECHO_EN
   input  logic           tx_busy,
   output logic           tx_start,
   output logic [7:0]     tx_data,
`endif
   output logic           set,
   output logic [7:0]     data_out,
   output logic [PTR_W:0] fifo_level,
   output logic           overflow
);

   localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP - 1);
   localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

   state_e           state_q, state_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic [7:0]       data_q, data_d;
   logic             ovf_q, ovf_d;

   logic             wr_keep;
   logic [7:0]       wr_byte;
   logic             pop;
   logic             can_pop;
   logic [7:0]       fifo_dout;
   logic             fifo_full, fifo_empty;

   assign wr_keep = rx_valid && char_keep(rx_data[6:0]);
   assign wr_byte = {rx_data[7], char_map(rx_data[6:0])};

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (wr_keep),
      .din     (wr_byte),
      .rd_en   (pop),
      .dout    (fifo_dout),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

`ifdef ECHO_EN
   assign can_pop = !fifo_empty && !tx_busy;
`else
   assign can_pop = !fifo_empty;
`endif

   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      data_d  = data_q;
      pop     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (can_pop) begin
               pop     = 1'b1;
               data_d  = fifo_dout;
               state_d = ST_STROBE;
            end
         end
         ST_STROBE: begin
            gap_d   = GAP_LOAD;
            state_d = ST_GAP;
         end
         ST_GAP: begin
            if (gap_q == '0) state_d = ST_IDLE;
            else             gap_d   = gap_q - GAP_ONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // A write that the FIFO refuses (full with no pop this cycle) is lost;
   // a fresh loss wins over a simultaneous clear.
   assign ovf_d = (wr_keep && fifo_full && !pop) || (ovf_q && !clr_ovf);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         gap_q   <= '0;
         data_q  <= 8'h00;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         gap_q   <= gap_d;
         data_q  <= data_d;
         ovf_q   <= ovf_d;
      end
   end

   // set is decoded from the state register so reset removes it at once.
   assign set      = (state_q == ST_STROBE);
   assign data_out = data_q;
   assign overflow = ovf_q;

`ifdef ECHO_EN
   assign tx_start = set;
   assign tx_data  = set ? data_q : 8'h00;
`endif

endmodule

// File: tb/tb_char_stream_feeder.sv
// tb/tb_char_stream_feeder.sv - directed table-driven bench for char_stream_feeder

module tb_char_stream_feeder;

   localparam int DEPTH = 16;
   localparam int GAP   = 4;
   localparam int PTR_W = 4;

   logic           clk = 1'b0;
   logic           reset_n;
   logic           rx_valid;
   logic [7:0]     rx_data;
   logic           clr_ovf;
   logic           set;
   logic [7:0]     data_out;
   logic [PTR_W:0] fifo_level;
   logic           overflow;
`ifdef ECHO_EN
   logic           tx_busy;
   logic           tx_start;
   logic [7:0]     tx_data;
`endif

   always #5 clk = ~clk;

   char_stream_feeder #(.DEPTH(DEPTH), .GAP(GAP)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .clr_ovf    (clr_ovf),
`ifdef ECHO_EN
      .tx_busy    (tx_busy),
      .tx_start   (tx_start),
      .tx_data    (tx_data),
`endif
      .set        (set),
      .data_out   (data_out),
      .fifo_level (fifo_level),
      .overflow   (overflow)
   );

   int nvec = 0;
   int nerr = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Strobe monitor, sampled on the falling edge.
   logic [7:0] got_q[$];
   int         t_q[$];
   int         cyc = 0;
   int         b2b = 0;
   int         peak = 0;
   logic       prev_set = 1'b0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (set === 1'b1) begin
         got_q.push_back(data_out);
         t_q.push_back(cyc);
         if (prev_set === 1'b1) b2b++;
      end
      prev_set = set;
      if (int'(fifo_level) > peak) peak = int'(fifo_level);
   end

   function automatic logic [7:0] got_at(input int k);
      if (k < got_q.size()) return got_q[k];
      return 8'hxx;
   endfunction

   function automatic int t_at(input int k);
      if (k < t_q.size()) return t_q[k];
      return -1000;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic send(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic clear_mon();
      got_q.delete();
      t_q.delete();
      b2b  = 0;
      peak = 0;
   endtask

   task automatic wait_set(output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 20 && !ok; n++) begin
         tick();
         if (set === 1'b1) ok = 1'b1;
      end
   endtask

   typedef struct {
      logic [7:0] rx;
      bit         keep;
      logic [7:0] exp;
   } vec_t;

   vec_t vt[12];

   initial begin
      #2_000_000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      bit ok;

      vt[0]  = '{8'h41, 1'b1, 8'h41};
      vt[1]  = '{8'hC2, 1'b1, 8'hC2};
      vt[2]  = '{8'h08, 1'b1, 8'h5C};
      vt[3]  = '{8'h88, 1'b1, 8'hDC};
      vt[4]  = '{8'h0A, 1'b0, 8'h00};
      vt[5]  = '{8'h8A, 1'b0, 8'h00};
      vt[6]  = '{8'h00, 1'b0, 8'h00};
      vt[7]  = '{8'h80, 1'b0, 8'h00};
      vt[8]  = '{8'h0D, 1'b1, 8'h0D};
      vt[9]  = '{8'h7F, 1'b1, 8'h7F};
      vt[10] = '{8'h2F, 1'b1, 8'h2F};
      vt[11] = '{8'hFF, 1'b1, 8'hFF};

      reset_n  = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      clr_ovf  = 1'b0;
`ifdef ECHO_EN
      tx_busy  = 1'b0;
`endif
      idle(2);
      check("rst_set", set, 1'b0);
      check("rst_data_out", data_out, 8'h00);
      check("rst_level", fifo_level, 0);
      check("rst_overflow", overflow, 1'b0);
`ifdef ECHO_EN
      check("rst_tx_start", tx_start, 1'b0);
      check("rst_tx_data", tx_data, 8'h00);
`endif
      reset_n = 1'b1;
      idle(2);

      // Two characters on consecutive cycles: strobes GAP+2 apart.
      clear_mon();
      send(8'h41);
      send(8'hC2);
      idle(20);
      check("pair_count", got_q.size(), 2);
      check("pair_0", got_at(0), 8'h41);
      check("pair_1", got_at(1), 8'hC2);
      check("pair_spacing", t_at(1) - t_at(0), GAP + 2);
      check("pair_b2b", b2b, 0);

      // Filter table, one byte at a time.
      for (int i = 0; i < 12; i++) begin
         clear_mon();
         send(vt[i].rx);
         idle(10);
         check($sformatf("filt_count_%02h", vt[i].rx), got_q.size(), vt[i].keep);
         if (vt[i].keep) check($sformatf("filt_data_%02h", vt[i].rx), got_at(0), vt[i].exp);
      end

      // Mixed sequence with drops; the queue builds to two entries.
      clear_mon();
      send(8'h41);
      send(8'h08);
      send(8'h0A);
      send(8'h00);
      send(8'h0D);
      idle(25);
      check("mix_count", got_q.size(), 3);
      check("mix_0", got_at(0), 8'h41);
      check("mix_1", got_at(1), 8'h5C);
      check("mix_2", got_at(2), 8'h0D);
      check("mix_peak", peak, 2);

      // 21-byte burst: pops at cycles 1,7,13,19 keep the FIFO at 16 from
      // byte 18; byte 19 lands with a pop on a full FIFO, byte 20 is lost.
      clear_mon();
      for (int i = 0; i < 21; i++) begin
         rx_data  = 8'h20 + 8'(i);
         rx_valid = 1'b1;
         tick();
         if (i == 18) begin
            check("burst_lvl_18", fifo_level, 16);
            check("burst_ovf_18", overflow, 1'b0);
         end
         if (i == 19) begin
            check("burst_lvl_full_pop", fifo_level, 16);
            check("burst_ovf_full_pop", overflow, 1'b0);
         end
         if (i == 20) begin
            check("burst_lvl_20", fifo_level, 16);
            check("burst_ovf_20", overflow, 1'b1);
         end
      end
      rx_valid = 1'b0;
      idle(140);
      check("burst_count", got_q.size(), 20);
      for (int k = 0; k < 20; k++)
         check($sformatf("burst_order_%0d", k), got_at(k), 8'h20 + 8'(k));
      check("burst_b2b", b2b, 0);
      check("ovf_sticky", overflow, 1'b1);
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      check("ovf_cleared", overflow, 1'b0);

      // Reset while in GAP with bytes still queued.
      clear_mon();
      for (int i = 0; i < 5; i++) send(8'h61 + 8'(i));
      wait_set(ok);
      check("gaprst_wait", ok, 1'b1);
      idle(2);
      check("gaprst_pre_level", fifo_level, 3);
      reset_n = 1'b0;
      #1;
      check("gaprst_set", set, 1'b0);
      check("gaprst_level", fifo_level, 0);
      check("gaprst_data", data_out, 8'h00);
      idle(1);
      reset_n = 1'b1;
      clear_mon();
      idle(40);
      check("gaprst_no_strobe", got_q.size(), 0);

      // Reset while set is high: the strobe drops without a clock edge.
      for (int i = 0; i < 5; i++) send(8'h71 + 8'(i));
      wait_set(ok);
      check("strrst_wait", ok, 1'b1);
      reset_n = 1'b0;
      #1;
      check("strrst_set", set, 1'b0);
      check("strrst_level", fifo_level, 0);
      idle(1);
      reset_n = 1'b1;
      clear_mon();
      idle(40);
      check("strrst_no_strobe", got_q.size(), 0);

`ifdef ECHO_EN
      // Echo path: transmitter busy holds the pop off.
      clear_mon();
      tx_busy = 1'b1;
      send(8'h41);
      idle(10);
      check("echo_held_count", got_q.size(), 0);
      check("echo_held_level", fifo_level, 1);
      tx_busy = 1'b0;
      wait_set(ok);
      check("echo_wait", ok, 1'b1);
      check("echo_tx_start", tx_start, 1'b1);
      check("echo_tx_data", tx_data, 8'h41);
      check("echo_data_out", data_out, 8'h41);
      idle(10);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
